// File: rtl/stream_pkg.sv
// Shared types and constants for the stream upsizer and its output buffer.
// word_t describes an output word in the default 4-bit x 2-lane geometry.
package stream_pkg;

    localparam int FIFO_DEPTH     = 2;
    localparam int DEF_DATA_WIDTH = 4;
    localparam int DEF_DATA_RATIO = 2;

    typedef struct packed {
        logic [DEF_DATA_RATIO-1:0][DEF_DATA_WIDTH-1:0] data;
        logic [DEF_DATA_RATIO-1:0]                     keep;
        logic                                          last;
    } word_t;

    // Width of an idle counter that must be able to hold the value 'timeout'.
    function automatic int idleWidth(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry output buffer; the head entry stays put until it is popped.
module stream_fifo2
    import stream_pkg::*;
#(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic valid_o,
    output logic full_o
);

    T           mem_q [FIFO_DEPTH];
    logic       wrPtr_q;
    logic       rdPtr_q;
    logic [1:0] count_q;
    logic       doPush;
    logic       doPop;

    assign valid_o = (count_q != 2'd0);
    assign full_o  = (count_q == 2'(FIFO_DEPTH));
    assign data_o  = mem_q[rdPtr_q];
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && valid_o;

    // Storage is cleared on reset so the idle output reads as all zeros.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wrPtr_q  <= 1'b0;
            rdPtr_q  <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= data_i;
                wrPtr_q        <= ~wrPtr_q;
            end
            if (doPop) begin
                rdPtr_q <= ~rdPtr_q;
            end
            count_q <= count_q + {1'b0, doPush} - {1'b0, doPop};
        end
    end

endmodule

// File: rtl/stream_upsize_dbuf.sv
// Packs narrow input beats into multi-lane output words, buffered in a
// two-entry FIFO, with an optional idle timeout that flushes partial words.
module stream_upsize_dbuf
    import stream_pkg::*;
#(
    parameter int T_DATA_WIDTH  = 4,
    parameter int T_DATA_RATIO  = 2,
    parameter int FLUSH_TIMEOUT = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [T_DATA_WIDTH-1:0] s_data_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o [T_DATA_RATIO-1:0],
    output logic [T_DATA_RATIO-1:0] m_keep_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
);

    localparam int CNT_W  = $clog2(T_DATA_RATIO);
    localparam int IDLE_W = idleWidth(FLUSH_TIMEOUT);

    typedef struct packed {
        logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] data;
        logic [T_DATA_RATIO-1:0]                   keep;
        logic                                      last;
    } upWord_t;

    logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] asmData_q, asmData_d, mergedData;
    logic [T_DATA_RATIO-1:0]                   keep_q, keep_d, mergedKeep;
    logic [CNT_W-1:0]                          cnt_q, cnt_d;
    logic [IDLE_W-1:0]                         idle_q, idle_d;
    logic    accept, lastLane, flushDue, doFlush, push, fifoFull, fifoValid;
    upWord_t pushWord, headWord;

    assign s_ready_o = !fifoFull;
    assign accept    = s_valid_i && s_ready_o;
    assign lastLane  = (cnt_q == CNT_W'(T_DATA_RATIO - 1));

    // Accepted beats take priority over a pending flush; a flush that finds the
    // FIFO full simply waits with the idle counter parked at the timeout.
    always_comb begin
        mergedData        = asmData_q;
        mergedData[cnt_q] = s_data_i;
        mergedKeep        = keep_q | (T_DATA_RATIO'(1) << cnt_q);
        flushDue  = (FLUSH_TIMEOUT > 0) && (keep_q != '0) &&
                    (idle_q >= IDLE_W'(FLUSH_TIMEOUT));
        doFlush   = flushDue && !accept && !fifoFull;
        push      = 1'b0;
        pushWord  = '0;
        cnt_d     = cnt_q;
        keep_d    = keep_q;
        asmData_d = asmData_q;
        idle_d    = idle_q;
        if (accept) begin
            idle_d = '0;
            if (lastLane || s_last_i) begin
                push          = 1'b1;
                pushWord.data = mergedData;
                pushWord.keep = mergedKeep;
                pushWord.last = s_last_i;
                cnt_d         = '0;
                keep_d        = '0;
                asmData_d     = '0;
            end else begin
                cnt_d     = cnt_q + CNT_W'(1);
                keep_d    = mergedKeep;
                asmData_d = mergedData;
            end
        end else if (doFlush) begin
            push          = 1'b1;
            pushWord.data = asmData_q;
            pushWord.keep = keep_q;
            pushWord.last = 1'b0;
            cnt_d         = '0;
            keep_d        = '0;
            asmData_d     = '0;
            idle_d        = '0;
        end else if ((FLUSH_TIMEOUT > 0) && (keep_q != '0) && !flushDue) begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            asmData_q <= '0;
            keep_q    <= '0;
            cnt_q     <= '0;
            idle_q    <= '0;
        end else begin
            asmData_q <= asmData_d;
            keep_q    <= keep_d;
            cnt_q     <= cnt_d;
            idle_q    <= idle_d;
        end
    end

    stream_fifo2 #(.T(upWord_t)) outFifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (pushWord),
        .pop_i   (m_ready_i),
        .data_o  (headWord),
        .valid_o (fifoValid),
        .full_o  (fifoFull)
    );

    always_comb begin
        for (int i = 0; i < T_DATA_RATIO; i++) begin
            m_data_o[i] = headWord.data[i];
        end
    end

    assign m_keep_o  = headWord.keep;
    assign m_last_o  = headWord.last;
    assign m_valid_o = fifoValid;

endmodule

// File: tb/tb_stream_upsize_dbuf.sv
// Self-checking bench: directed vector table, directed corner sequences and
// randomized traffic compared against a queue-based packing model.
module tb_stream_upsize_dbuf;

    localparam int W = 4;
    localparam int R = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sData = '0;
    logic         sLast = 1'b0, sValid = 1'b0, sReady;
    logic [W-1:0] mData [R-1:0];
    logic [R-1:0] mKeep;
    logic         mLast, mValid, mReady = 1'b0;

    logic [W-1:0] fData = '0;
    logic         fLast = 1'b0, fValid = 1'b0, fReady;
    logic [W-1:0] fmData [R-1:0];
    logic [R-1:0] fmKeep;
    logic         fmLast, fmValid, fmReady = 1'b1;

    always #5 clk = ~clk;

    stream_upsize_dbuf #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R), .FLUSH_TIMEOUT(0)) dut (
        .clk(clk), .rst_n(rst_n), .s_data_i(sData), .s_last_i(sLast), .s_valid_i(sValid),
        .s_ready_o(sReady), .m_data_o(mData), .m_keep_o(mKeep), .m_last_o(mLast),
        .m_valid_o(mValid), .m_ready_i(mReady)
    );

    stream_upsize_dbuf #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R), .FLUSH_TIMEOUT(3)) dutFlush (
        .clk(clk), .rst_n(rst_n), .s_data_i(fData), .s_last_i(fLast), .s_valid_i(fValid),
        .s_ready_o(fReady), .m_data_o(fmData), .m_keep_o(fmKeep), .m_last_o(fmLast),
        .m_valid_o(fmValid), .m_ready_i(fmReady)
    );

    typedef struct {
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        logic [1:0]   keep;
        logic         last;
    } expWord_t;

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         l;
        logic         expValid;
        logic [W-1:0] e0;
        logic [W-1:0] e1;
        logic [1:0]   ek;
        logic         el;
    } vec_t;

    expWord_t     outQ [$];
    logic [W-1:0] beats [$];
    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle on the main DUT: drive, compare against the model, then advance the model.
    task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic l,
                                 input logic mr, output logic accepted);
        logic     popNow;
        expWord_t w;
        @(negedge clk);
        sValid = v;
        sData  = d;
        sLast  = l;
        mReady = mr;
        #1;
        checkOutput("s_ready", sReady, outQ.size() < 2);
        checkOutput("m_valid", mValid, outQ.size() > 0);
        if (outQ.size() > 0) begin
            checkOutput("lane0", mData[0], outQ[0].d0);
            checkOutput("lane1", mData[1], outQ[0].d1);
            checkOutput("keep", mKeep, outQ[0].keep);
            checkOutput("last", mLast, outQ[0].last);
        end
        accepted = v && (outQ.size() < 2);
        popNow   = mr && (outQ.size() > 0);
        @(posedge clk);
        if (popNow) void'(outQ.pop_front());
        if (accepted) begin
            beats.push_back(d);
            if (beats.size() == R || l) begin
                w.d0   = beats[0];
                w.d1   = (beats.size() > 1) ? beats[1] : '0;
                w.keep = (beats.size() > 1) ? 2'b11 : 2'b01;
                w.last = l;
                outQ.push_back(w);
                beats.delete();
            end
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n  = 1'b0;
        sValid = 1'b0;
        fValid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_m_valid", mValid, 0);
        checkOutput("rst_m_keep", mKeep, 0);
        checkOutput("rst_m_last", mLast, 0);
        checkOutput("rst_lane0", mData[0], 0);
        checkOutput("rst_lane1", mData[1], 0);
        checkOutput("rst_s_ready", sReady, 1);
        checkOutput("rst_f_valid", fmValid, 0);
        checkOutput("rst_f_keep", fmKeep, 0);
        @(negedge clk);
        rst_n = 1'b1;
        outQ.delete();
        beats.delete();
    endtask

    initial begin
        vec_t         vecs [8];
        logic         a;
        int           idx, acc, words, prevCyc;
        logic [W-1:0] stallBeats [8];

        vecs[0] = '{1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0};
        vecs[1] = '{1'b1, 4'h1, 1'b0, 1'b1, 4'h0, 4'h1, 2'b11, 1'b0};
        vecs[2] = '{1'b1, 4'h2, 1'b1, 1'b1, 4'h2, 4'h0, 2'b01, 1'b1};
        vecs[3] = '{1'b1, 4'hA, 1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0};
        vecs[4] = '{1'b1, 4'hB, 1'b1, 1'b1, 4'hA, 4'hB, 2'b11, 1'b1};
        vecs[5] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0};
        vecs[6] = '{1'b1, 4'hB, 1'b1, 1'b1, 4'hB, 4'h0, 2'b01, 1'b1};
        vecs[7] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0};

        doReset();

        // Vector table with m_ready held high; each row is checked one edge later.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sValid = vecs[i].v;
            sData  = vecs[i].d;
            sLast  = vecs[i].l;
            mReady = 1'b1;
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_valid", i), mValid, vecs[i].expValid);
            checkOutput($sformatf("vec%0d_ready", i), sReady, 1);
            if (vecs[i].expValid) begin
                checkOutput($sformatf("vec%0d_lane0", i), mData[0], vecs[i].e0);
                checkOutput($sformatf("vec%0d_lane1", i), mData[1], vecs[i].e1);
                checkOutput($sformatf("vec%0d_keep", i), mKeep, vecs[i].ek);
                checkOutput($sformatf("vec%0d_last", i), mLast, vecs[i].el);
            end
        end

        // Downstream stalled for 10 cycles while 8 beats are offered.
        doReset();
        for (int i = 0; i < 8; i++) stallBeats[i] = 4'(i + 1);
        idx = 0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b1, stallBeats[idx], idx == 7, 1'b0, a);
            if (a) begin
                idx++;
                acc++;
            end
        end
        checkOutput("stall_accepted", acc, 4);
        #1;
        checkOutput("stall_s_ready", sReady, 0);
        checkOutput("stall_hold_lane0", mData[0], 1);
        checkOutput("stall_hold_lane1", mData[1], 2);
        for (int c = 0; c < 20 && idx < 8; c++) begin
            applyStimulus(1'b1, stallBeats[idx], idx == 7, 1'b1, a);
            if (a) idx++;
        end
        checkOutput("release_all_beats", idx, 8);
        for (int c = 0; c < 4; c++) applyStimulus(1'b0, '0, 1'b0, 1'b1, a);
        checkOutput("release_drained", outQ.size(), 0);

        // Reset in the middle of a packet discards everything in flight.
        doReset();
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 4'(i), 1'b0, 1'b1, a);
        doReset();
        for (int c = 0; c < 3; c++) applyStimulus(1'b0, '0, 1'b0, 1'b1, a);
        applyStimulus(1'b1, 4'h7, 1'b0, 1'b1, a);
        applyStimulus(1'b1, 4'h8, 1'b1, 1'b1, a);
        #1;
        checkOutput("postrst_valid", mValid, 1);
        checkOutput("postrst_lane0", mData[0], 7);
        checkOutput("postrst_lane1", mData[1], 8);
        checkOutput("postrst_keep", mKeep, 2'b11);
        checkOutput("postrst_last", mLast, 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, a);

        // Sustained throughput: 100 back-to-back beats, one word every R cycles.
        doReset();
        words   = 0;
        prevCyc = -1;
        acc     = 0;
        for (int c = 0; c < 100; c++) begin
            applyStimulus(1'b1, 4'($urandom), 1'b0, 1'b1, a);
            if (a) acc++;
            #1;
            if (mValid) begin
                if (prevCyc >= 0) checkOutput("word_spacing", c - prevCyc, R);
                prevCyc = c;
                words++;
            end
        end
        checkOutput("stream_accepted", acc, 100);
        checkOutput("stream_words", words, 50);
        for (int c = 0; c < 3; c++) applyStimulus(1'b0, '0, 1'b0, 1'b1, a);

        // Randomized traffic against the packing model.
        doReset();
        for (int c = 0; c < 400; c++) begin
            applyStimulus($urandom_range(0, 99) < 70, 4'($urandom),
                          $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 60, a);
        end
        for (int c = 0; c < 6; c++) applyStimulus(1'b0, '0, 1'b0, 1'b1, a);
        checkOutput("random_drained", outQ.size(), 0);

        // Idle flush on the timeout instance: one beat, then three idle cycles.
        doReset();
        @(negedge clk);
        fValid  = 1'b1;
        fData   = 4'hA;
        fLast   = 1'b0;
        fmReady = 1'b1;
        #1;
        checkOutput("flush_accept_ready", fReady, 1);
        @(posedge clk);
        @(negedge clk);
        fValid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("flush_valid_c%0d", i), fmValid, i == 4);
            if (i == 4) begin
                checkOutput("flush_lane0", fmData[0], 4'hA);
                checkOutput("flush_lane1", fmData[1], 4'h0);
                checkOutput("flush_keep", fmKeep, 2'b01);
                checkOutput("flush_last", fmLast, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
